// File: rtl/riscv_pkg.sv
// Shared pipeline encodings: EX-stage PC condition codes and hazard controller FSM states.
package riscv_pkg;

   localparam logic [1:0] PC_COND_NONE = 2'b00;
   localparam logic [1:0] PC_COND_BR   = 2'b01;
   localparam logic [1:0] PC_COND_JAL  = 2'b10;
   localparam logic [1:0] PC_COND_JALR = 2'b11;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      ERR      = 2'b10
   } hazard_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up while below all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: RAM-wait freeze, branch/jump redirect flush and load-use stall,
// with a RAM wait-time watchdog (sticky bus_error) and saturating stall/flush counters.
module pipeline_hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd_addr,
   input  logic             ex_is_load,
   input  logic [1:0]       ex_pc_condition,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_hold,
   output logic             if_id_hold,
   output logic             if_id_flush,
   output logic             id_ex_hold,
   output logic             id_ex_flush,
   output logic             ex_mem_hold,
   output logic             mem_wb_flush,
   output logic             pc_redirect,
   output logic             bus_error,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

   hazard_state_e     state_r;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic              bus_error_r;
   logic              freeze_s;
   logic              redirect_s;
   logic              load_use_s;

   // Hazard detection; rst_n gating keeps every control output low while reset is asserted
   always_comb begin
      freeze_s   = rst_n & ((state_r == ERR) | (mem_req & ~mem_ready));
      redirect_s = rst_n & (ex_pc_condition[1] |
                            ((ex_pc_condition == PC_COND_BR) & ex_branch_taken));
      load_use_s = rst_n & ex_is_load & (ex_rd_addr != 5'd0) &
                   ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                    (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));
   end

   // Priority resolution: freeze defers everything, redirect discards the ID instruction
   always_comb begin
      pc_hold      = 1'b0;
      if_id_hold   = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_hold   = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_hold  = 1'b0;
      mem_wb_flush = 1'b0;
      pc_redirect  = 1'b0;
      if (freeze_s) begin
         pc_hold      = 1'b1;
         if_id_hold   = 1'b1;
         id_ex_hold   = 1'b1;
         ex_mem_hold  = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (redirect_s) begin
         pc_redirect  = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
      end else if (load_use_s) begin
         pc_hold      = 1'b1;
         if_id_hold   = 1'b1;
         id_ex_flush  = 1'b1;
      end else begin
         pc_hold      = 1'b0;
      end
   end

   // RAM wait watchdog; ERR is terminal until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= RUN;
         wait_cnt_r  <= '0;
         bus_error_r <= 1'b0;
      end else begin
         case (state_r)
            RUN: begin
               if (mem_req && !mem_ready) begin
                  state_r    <= MEM_WAIT;
                  wait_cnt_r <= WAIT_W'(1);
               end else begin
                  wait_cnt_r <= '0;
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  state_r    <= RUN;
                  wait_cnt_r <= '0;
               end else if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT - 1)) begin
                  state_r     <= ERR;
                  bus_error_r <= 1'b1;
               end else begin
                  wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
               end
            end
            ERR: begin
               bus_error_r <= 1'b1;
            end
            default: begin
               state_r     <= ERR;
               bus_error_r <= 1'b1;
            end
         endcase
      end
   end

   assign bus_error = bus_error_r;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pc_hold),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pc_redirect),
      .count (flush_cnt)
   );

endmodule
